// File: rtl/counter_8_checker_pkg.sv
// Shared types and default constants for the counter_8 sequence checker.
package counter_8_pkg;

  // Checker is either searching for a clean run or tracking a locked sequence.
  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  localparam int DEF_WIDTH     = 3;
  localparam int DEF_LOCK_LEN  = 4;
  localparam int DEF_ERR_LIMIT = 3;
  localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/counter_8_checker_if.sv
// Bundle carrying the checked count and the checker's status outputs.
interface counter_8_checker_if
  import counter_8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic [WIDTH-1:0] q;
  logic             locked;
  logic             err;
  logic             wrap;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] wrap_count;

  // Source side: supplies the count, observes the verdicts.
  modport master (
    output q,
    input  locked, err, wrap, err_count, wrap_count
  );

  // Checker side.
  modport slave (
    input  q,
    output locked, err, wrap, err_count, wrap_count
  );

endinterface

// File: rtl/counter_8_checker_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Advance only while there is headroom left.
  always_comb begin
    value_d = value_q;
    if (inc && (value_q != {W{1'b1}})) begin
      value_d = value_q + W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/counter_8_checker.sv
// Checks that q advances by one (mod 2^WIDTH) every clock; locks after a
// clean run, reports and counts deviations and wraps while locked.
module counter_8_checker
  import counter_8_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LOCK_LEN  = DEF_LOCK_LEN,
  parameter int ERR_LIMIT = DEF_ERR_LIMIT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  counter_8_checker_if.slave  bus
);

  chk_state_t       state_q, state_d;
  logic [WIDTH-1:0] q_prev_q, q_prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic [3:0]       run_q, run_d;
  logic [3:0]       miss_q, miss_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] wrap_count_q, wrap_count_d;
  logic [WIDTH-1:0] q_expect;
  logic             match;

  // Next-state logic: q_prev always follows q so a jump resynchronises the
  // expectation; the first sample after reset is neither match nor mismatch.
  always_comb begin
    q_expect     = q_prev_q + WIDTH'(1);
    match        = prev_valid_q && (bus.q == q_expect);
    state_d      = state_q;
    q_prev_d     = bus.q;
    prev_valid_d = 1'b1;
    run_d        = run_q;
    miss_d       = miss_q;
    err_d        = 1'b0;
    wrap_d       = 1'b0;
    wrap_count_d = wrap_count_q;
    if (prev_valid_q) begin
      case (state_q)
        HUNT: begin
          if (match) begin
            run_d = run_q + 4'd1;
            if ((run_q + 4'd1) == 4'(LOCK_LEN)) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end
          end else begin
            run_d = 4'd0;
          end
        end
        LOCKED: begin
          if (match) begin
            miss_d = 4'd0;
            if (bus.q == '0) begin
              wrap_d       = 1'b1;
              wrap_count_d = wrap_count_q + CNT_W'(1);
            end
          end else begin
            err_d  = 1'b1;
            miss_d = miss_q + 4'd1;
            if ((miss_q + 4'd1) == 4'(ERR_LIMIT)) begin
              state_d = HUNT;
              run_d   = 4'd0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State and status registers; reset overrides any event on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= HUNT;
      q_prev_q     <= '0;
      prev_valid_q <= 1'b0;
      run_q        <= 4'd0;
      miss_q       <= 4'd0;
      err_q        <= 1'b0;
      wrap_q       <= 1'b0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      q_prev_q     <= q_prev_d;
      prev_valid_q <= prev_valid_d;
      run_q        <= run_d;
      miss_q       <= miss_d;
      err_q        <= err_d;
      wrap_q       <= wrap_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  // Error total saturates so a long fault burst cannot alias back to zero.
  sat_counter #(
    .W (CNT_W)
  ) u_err_count (
    .clock (clock),
    .reset (reset),
    .inc   (err_d),
    .value (bus.err_count)
  );

  assign bus.locked     = (state_q == LOCKED);
  assign bus.err        = err_q;
  assign bus.wrap       = wrap_q;
  assign bus.wrap_count = wrap_count_q;

endmodule

// File: tb/tb_counter_8_checker.sv
// Bench for counter_8_checker: a default instance and a CNT_W=2/ERR_LIMIT=15
// instance share one stimulus stream and are compared against a cycle model.
module tb_counter_8_checker;

  logic       clock;
  logic       reset;
  logic [2:0] q_drv;
  bit         cmp_en;
  int         n_cmp;
  int         n_fail;

  counter_8_checker_if #(.WIDTH(3), .CNT_W(8)) if_a ();
  counter_8_checker_if #(.WIDTH(3), .CNT_W(2)) if_b ();

  assign if_a.q = q_drv;
  assign if_b.q = q_drv;

  counter_8_checker u_dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (if_a.slave)
  );

  counter_8_checker #(
    .WIDTH     (3),
    .LOCK_LEN  (4),
    .ERR_LIMIT (15),
    .CNT_W     (2)
  ) u_dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (if_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int prev;
    bit pv;
    int run;
    int miss;
    bit locked;
    bit err;
    bit wrap;
    int ec;
    int wc;
  } mdl_t;

  mdl_t ma;
  mdl_t mb;

  // One clock of the checker's rules, in plain integer arithmetic.
  function automatic mdl_t mstep(mdl_t m, int qv, bit rst, int lock_len,
                                 int err_limit, int cnt_w);
    mdl_t n;
    bit   match;
    n      = m;
    n.err  = 1'b0;
    n.wrap = 1'b0;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    match = m.pv && (qv == ((m.prev + 1) % 8));
    if (m.pv) begin
      if (!m.locked) begin
        if (match) begin
          n.run = m.run + 1;
          if (n.run == lock_len) begin
            n.locked = 1'b1;
            n.miss   = 0;
          end
        end else begin
          n.run = 0;
        end
      end else begin
        if (match) begin
          n.miss = 0;
          if (qv == 0) begin
            n.wrap = 1'b1;
            n.wc   = (m.wc + 1) % (1 << cnt_w);
          end
        end else begin
          n.err  = 1'b1;
          n.ec   = (m.ec + 1 > (1 << cnt_w) - 1) ? (1 << cnt_w) - 1 : m.ec + 1;
          n.miss = m.miss + 1;
          if (n.miss == err_limit) begin
            n.locked = 1'b0;
            n.run    = 0;
          end
        end
      end
    end
    n.prev = qv;
    n.pv   = 1'b1;
    return n;
  endfunction

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
  end

  always @(posedge clock) begin
    ma = mstep(ma, int'(q_drv), reset, 4, 3, 8);
    mb = mstep(mb, int'(q_drv), reset, 4, 15, 2);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, both instances against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("a_locked", 32'(if_a.locked), 32'(ma.locked));
      chk("a_err", 32'(if_a.err), 32'(ma.err));
      chk("a_wrap", 32'(if_a.wrap), 32'(ma.wrap));
      chk("a_err_count", 32'(if_a.err_count), 32'(ma.ec));
      chk("a_wrap_count", 32'(if_a.wrap_count), 32'(ma.wc));
      chk("b_locked", 32'(if_b.locked), 32'(mb.locked));
      chk("b_err", 32'(if_b.err), 32'(mb.err));
      chk("b_wrap", 32'(if_b.wrap), 32'(mb.wrap));
      chk("b_err_count", 32'(if_b.err_count), 32'(mb.ec));
      chk("b_wrap_count", 32'(if_b.wrap_count), 32'(mb.wc));
      chk("a_err_wrap_excl", 32'(if_a.err & if_a.wrap), 32'd0);
    end
  end

  task automatic step(input int v);
    q_drv = 3'(v);
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cmp_en = 1'b0;
    reset  = 1'b1;
    q_drv  = 3'd0;
    step(0);
    step(0);
    cmp_en = 1'b1;
    chk("rst_locked", 32'(if_a.locked), 32'd0);
    chk("rst_err", 32'(if_a.err), 32'd0);
    chk("rst_err_count", 32'(if_a.err_count), 32'd0);
    chk("rst_wrap_count", 32'(if_a.wrap_count), 32'd0);
    reset = 1'b0;

    // Clean count from 5: lock after the edge sampling 1.
    step(5); step(6); step(7); step(0);
    chk("lock_not_yet", 32'(if_a.locked), 32'd0);
    chk("hunt_no_wrap", 32'(if_a.wrap), 32'd0);
    step(1);
    chk("lock_at_1", 32'(if_a.locked), 32'd1);
    for (int i = 0; i < 16; i++) step((2 + i) % 8);
    chk("clean_wraps", 32'(if_a.wrap_count), 32'd2);
    chk("clean_errs", 32'(if_a.err_count), 32'd0);

    // Single glitch while locked.
    step(2); step(3); step(4); step(6);
    chk("glitch_err", 32'(if_a.err), 32'd1);
    chk("glitch_count", 32'(if_a.err_count), 32'd1);
    step(7);
    chk("glitch_locked", 32'(if_a.locked), 32'd1);
    step(0);
    chk("glitch_wrap", 32'(if_a.wrap), 32'd1);
    chk("glitch_wrap_count", 32'(if_a.wrap_count), 32'd3);

    // Stuck at 2: three errors, lock lost on the third.
    step(1); step(2);
    step(2); step(2); step(2);
    chk("stuck_unlock", 32'(if_a.locked), 32'd0);
    chk("stuck_err3", 32'(if_a.err), 32'd1);
    chk("stuck_count", 32'(if_a.err_count), 32'd4);
    chk("stuck_b_locked", 32'(if_b.locked), 32'd1);
    step(2); step(2);
    chk("stuck_uncounted_err", 32'(if_a.err), 32'd0);
    chk("stuck_uncounted", 32'(if_a.err_count), 32'd4);
    step(3); step(4); step(5);
    chk("relock_not_yet", 32'(if_a.locked), 32'd0);
    step(6);
    chk("relock_at_6", 32'(if_a.locked), 32'd1);

    // One-cycle reset while locked.
    reset = 1'b1;
    step(7);
    reset = 1'b0;
    chk("mid_rst_locked", 32'(if_a.locked), 32'd0);
    chk("mid_rst_err_count", 32'(if_a.err_count), 32'd0);
    chk("mid_rst_wrap_count", 32'(if_a.wrap_count), 32'd0);
    chk("mid_rst_b_err_count", 32'(if_b.err_count), 32'd0);
    step(0); step(1); step(2); step(3);
    chk("post_rst_not_yet", 32'(if_a.locked), 32'd0);
    step(4);
    chk("post_rst_lock", 32'(if_a.locked), 32'd1);

    // Alternating glitches: B saturates at 3, A keeps counting.
    step(6); step(7); step(1); step(2); step(4);
    chk("sat_at_3", 32'(if_b.err_count), 32'd3);
    step(5); step(7);
    chk("sat_holds", 32'(if_b.err_count), 32'd3);
    step(0); step(2);
    chk("sat_final_b", 32'(if_b.err_count), 32'd3);
    chk("alt_final_a", 32'(if_a.err_count), 32'd5);
    chk("alt_a_locked", 32'(if_a.locked), 32'd1);
    chk("alt_wrap_a", 32'(if_a.wrap_count), 32'd1);

    // Wrap counter modulo behaviour on the 2-bit instance.
    for (int i = 0; i < 32; i++) step((3 + i) % 8);
    chk("wrap_a_5", 32'(if_a.wrap_count), 32'd5);
    chk("wrap_b_roll", 32'(if_b.wrap_count), 32'd1);

    // Down-counting never locks.
    reset = 1'b1;
    step(0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) step(7 - (i % 8));
    chk("down_locked", 32'(if_a.locked), 32'd0);
    chk("down_err_count", 32'(if_a.err_count), 32'd0);
    chk("down_wrap_count", 32'(if_a.wrap_count), 32'd0);
    chk("down_b_locked", 32'(if_b.locked), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
